// File: rtl/hazard_pkg.sv
// Shared types and select encodings for the pipeline hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // Operand select: 0 = regfile, k+1 = downstream stage k, NUM_FWD+1 = multicycle result.
    localparam int SEL_RF = 0;

    function automatic int SEL_MC(input int num_fwd);
        return num_fwd + 1;
    endfunction

    function automatic int selw(input int num_fwd);
        return $clog2(num_fwd + 2);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the pipeline, slave is the hazard unit.
interface hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int AW      = 5,
    parameter int SELW    = selw(NUM_FWD)
) ();

    logic                  id_valid;
    logic [AW-1:0]         id_rs1;
    logic [AW-1:0]         id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [AW-1:0]         id_rd;
    logic                  id_wreg;
    logic                  id_is_mc;
    logic [NUM_FWD*AW-1:0] fwd_rd;
    logic [NUM_FWD-1:0]    fwd_wreg;
    logic                  ex_is_load;
    logic                  br_taken;

    logic [SELW-1:0]       qa_sel;
    logic [SELW-1:0]       qb_sel;
    logic                  pc_stall;
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  mc_busy;
    logic                  mc_done;
    logic [AW-1:0]         mc_rd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wreg,
               id_is_mc, fwd_rd, fwd_wreg, ex_is_load, br_taken,
        input  qa_sel, qb_sel, pc_stall, ifid_stall, ifid_flush, idex_bubble,
               mc_busy, mc_done, mc_rd
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wreg,
               id_is_mc, fwd_rd, fwd_wreg, ex_is_load, br_taken,
        output qa_sel, qb_sel, pc_stall, ifid_stall, ifid_flush, idex_bubble,
               mc_busy, mc_done, mc_rd
    );

endinterface

// File: rtl/fwd_match.sv
// Per-operand source matcher: picks the forwarding source with lowest-stage priority
// and flags matches against EXE and the in-flight multicycle destination.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int AW      = 5,
    parameter int SELW    = selw(NUM_FWD)
) (
    input  logic [AW-1:0]         rs_i,
    input  logic                  use_i,
    input  logic [NUM_FWD*AW-1:0] fwd_rd_i,
    input  logic [NUM_FWD-1:0]    fwd_wreg_i,
    input  logic [AW-1:0]         mc_rd_i,
    input  logic                  mc_done_i,
    output logic [SELW-1:0]       sel_o,
    output logic                  ex_hit_o,
    output logic                  mc_hit_o
);

    // x0 is hardwired, so it never matches anything.
    logic src_ok;
    assign src_ok   = use_i & (|rs_i);
    assign mc_hit_o = src_ok & (rs_i == mc_rd_i);
    assign ex_hit_o = src_ok & fwd_wreg_i[0] & (fwd_rd_i[AW-1:0] == rs_i);

    always_comb begin
        sel_o = SELW'(SEL_RF);
        if (mc_done_i && mc_hit_o) begin
            sel_o = SELW'(SEL_MC(NUM_FWD));
        end
        // Walk from the oldest stage down so the youngest matching stage wins.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (src_ok && fwd_wreg_i[k] && (fwd_rd_i[k*AW +: AW] == rs_i)) begin
                sel_o = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and multicycle stalls, branch flush, operand
// forwarding selects, and the multicycle-unit tracking FSM.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int MC_LAT  = 4,
    parameter int AW      = 5
) (
    input  logic         clk,
    input  logic         resetn,
    hazard_unit_if.slave bus
);

    localparam int SELW = selw(NUM_FWD);
    localparam int CW   = $clog2(MC_LAT);

    mc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mc_rd_q, mc_rd_d;

    logic busy, done;
    logic ex_hit_a, ex_hit_b, mc_hit_a, mc_hit_b;
    logic lu_stall, raw_stall, waw_stall, st_stall;
    logic stall, accept;
    logic [SELW-1:0] sel_a, sel_b;

    assign busy = (state_q == MC_BUSY);
    assign done = (state_q == MC_DONE);

    fwd_match #(.NUM_FWD(NUM_FWD), .AW(AW), .SELW(SELW)) u_match_rs1 (
        .rs_i       (bus.id_rs1),
        .use_i      (bus.id_use_rs1),
        .fwd_rd_i   (bus.fwd_rd),
        .fwd_wreg_i (bus.fwd_wreg),
        .mc_rd_i    (mc_rd_q),
        .mc_done_i  (done),
        .sel_o      (sel_a),
        .ex_hit_o   (ex_hit_a),
        .mc_hit_o   (mc_hit_a)
    );

    fwd_match #(.NUM_FWD(NUM_FWD), .AW(AW), .SELW(SELW)) u_match_rs2 (
        .rs_i       (bus.id_rs2),
        .use_i      (bus.id_use_rs2),
        .fwd_rd_i   (bus.fwd_rd),
        .fwd_wreg_i (bus.fwd_wreg),
        .mc_rd_i    (mc_rd_q),
        .mc_done_i  (done),
        .sel_o      (sel_b),
        .ex_hit_o   (ex_hit_b),
        .mc_hit_o   (mc_hit_b)
    );

    assign lu_stall  = bus.ex_is_load & (ex_hit_a | ex_hit_b);
    assign raw_stall = busy & (mc_hit_a | mc_hit_b);
    assign waw_stall = busy & bus.id_wreg & (|bus.id_rd) & (bus.id_rd == mc_rd_q);
    assign st_stall  = busy & bus.id_is_mc;
    assign stall     = bus.id_valid & (lu_stall | raw_stall | waw_stall | st_stall);
    assign accept    = bus.id_valid & bus.id_is_mc & ~stall & ~bus.br_taken;

    // A taken branch discards the ID instruction, so it overrides any stall.
    assign bus.pc_stall    = stall & ~bus.br_taken;
    assign bus.ifid_stall  = stall & ~bus.br_taken;
    assign bus.ifid_flush  = bus.br_taken;
    assign bus.idex_bubble = stall | bus.br_taken;
    assign bus.qa_sel      = sel_a;
    assign bus.qb_sel      = sel_b;
    assign bus.mc_busy     = busy;
    assign bus.mc_done     = done;
    assign bus.mc_rd       = mc_rd_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            mc_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    // Counter starts at MC_LAT-2 so DONE lands exactly MC_LAT cycles after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        case (state_q)
            MC_IDLE, MC_DONE: begin
                if (accept) begin
                    mc_rd_d = bus.id_rd;
                    cnt_d   = CW'(MC_LAT - 2);
                    state_d = MC_BUSY;
                end else begin
                    state_d = MC_IDLE;
                end
            end
            MC_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: hand-derived expectations queued per step and
// compared against the combinational outputs mid-cycle.
module tb_hazard_unit;

    localparam int NUM_FWD = 2;
    localparam int MC_LAT  = 4;
    localparam int AW      = 5;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    logic clk;
    logic resetn;
    exp_t sb[$];
    int   total;
    int   bad;

    hazard_unit_if #(.NUM_FWD(NUM_FWD), .AW(AW)) bus ();

    hazard_unit #(.NUM_FWD(NUM_FWD), .MC_LAT(MC_LAT), .AW(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, mc_busy, mc_done, qa_sel, qb_sel, mc_rd}
    function automatic logic [14:0] observed();
        return {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble,
                bus.mc_busy, bus.mc_done, bus.qa_sel, bus.qb_sel, bus.mc_rd};
    endfunction

    task automatic clear_inputs();
        bus.id_valid   = 1'b0;
        bus.id_rs1     = '0;
        bus.id_rs2     = '0;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
        bus.id_rd      = '0;
        bus.id_wreg    = 1'b0;
        bus.id_is_mc   = 1'b0;
        bus.fwd_rd     = '0;
        bus.fwd_wreg   = '0;
        bus.ex_is_load = 1'b0;
        bus.br_taken   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ctl, input logic [1:0] mc,
                              input logic [1:0] qa, input logic [1:0] qb, input logic [4:0] mrd);
        exp_t e;
        e.tag = tag;
        e.v   = {ctl, mc, qa, qb, mrd};
        sb.push_back(e);
    endtask

    // Sample on the falling edge, then return just after the next rising edge.
    task automatic check();
        exp_t        e;
        logic [14:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observed();
            total++;
            assert (obs === e.v)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mc_issue(input logic [4:0] rd);
        clear_inputs();
        bus.id_valid = 1'b1;
        bus.id_is_mc = 1'b1;
        bus.id_wreg  = 1'b1;
        bus.id_rd    = rd;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        expect_out("reset", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd0);
        check();
        resetn = 1'b1;

        // Load-use: load x5 in EXE, ID reads x5.
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        bus.fwd_rd = {5'd0, 5'd5}; bus.fwd_wreg = 2'b01; bus.ex_is_load = 1'b1;
        expect_out("lu_stall", 4'b1101, 2'b00, 2'd1, 2'd0, 5'd0);
        check();
        bus.fwd_rd = {5'd5, 5'd0}; bus.fwd_wreg = 2'b10; bus.ex_is_load = 1'b0;
        expect_out("lu_fwd_mem", 4'b0000, 2'b00, 2'd2, 2'd0, 5'd0);
        check();

        // EXE and MEM both write x7.
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
        bus.fwd_rd = {5'd7, 5'd7}; bus.fwd_wreg = 2'b11;
        expect_out("exe_wins", 4'b0000, 2'b00, 2'd0, 2'd1, 5'd0);
        check();
        bus.fwd_wreg = 2'b10;
        expect_out("mem_only", 4'b0000, 2'b00, 2'd0, 2'd2, 5'd0);
        check();
        bus.fwd_wreg = 2'b11; bus.id_use_rs2 = 1'b0;
        expect_out("unused_src", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd0);
        check();

        // Multicycle op rd=3, consumer of x3 stalls until DONE.
        mc_issue(5'd3);
        expect_out("mc3_accept", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd0);
        check();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1'b1;
        bus.id_wreg = 1'b1; bus.id_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("mc3_raw_%0d", i), 4'b1101, 2'b10, 2'd0, 2'd0, 5'd3);
            check();
        end
        expect_out("mc3_done_fwd", 4'b0000, 2'b01, 2'd3, 2'd0, 5'd3);
        check();
        clear_inputs();
        expect_out("mc3_idle", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd3);
        check();

        // Back-to-back multicycle ops: second one waits, then issues from DONE.
        mc_issue(5'd8);
        expect_out("mc8_accept", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd3);
        check();
        mc_issue(5'd9);
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("mc9_struct_%0d", i), 4'b1101, 2'b10, 2'd0, 2'd0, 5'd8);
            check();
        end
        expect_out("mc9_accept_done", 4'b0000, 2'b01, 2'd0, 2'd0, 5'd8);
        check();
        clear_inputs();
        expect_out("mc9_busy_direct", 4'b0000, 2'b10, 2'd0, 2'd0, 5'd9);
        check();
        bus.id_valid = 1'b1; bus.id_wreg = 1'b1; bus.id_rd = 5'd9;
        expect_out("mc9_waw", 4'b1101, 2'b10, 2'd0, 2'd0, 5'd9);
        check();
        bus.id_valid = 1'b0;
        expect_out("mc9_waw_invalid", 4'b0000, 2'b10, 2'd0, 2'd0, 5'd9);
        check();
        clear_inputs();
        expect_out("mc9_done", 4'b0000, 2'b01, 2'd0, 2'd0, 5'd9);
        check();
        expect_out("mc9_idle", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd9);
        check();

        // Branch overrides load-use and blocks mc acceptance.
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        bus.fwd_rd = {5'd0, 5'd5}; bus.fwd_wreg = 2'b01; bus.ex_is_load = 1'b1;
        bus.br_taken = 1'b1;
        expect_out("br_over_lu", 4'b0011, 2'b00, 2'd1, 2'd0, 5'd9);
        check();
        mc_issue(5'd6);
        bus.br_taken = 1'b1;
        expect_out("br_mc_issue", 4'b0011, 2'b00, 2'd0, 2'd0, 5'd9);
        check();
        clear_inputs();
        expect_out("br_mc_dropped", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd9);
        check();

        // Branch while an mc op is in flight does not cancel it.
        mc_issue(5'd10);
        expect_out("mc10_accept", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd9);
        check();
        clear_inputs();
        bus.br_taken = 1'b1;
        expect_out("mc10_br", 4'b0011, 2'b10, 2'd0, 2'd0, 5'd10);
        check();
        clear_inputs();
        expect_out("mc10_busy_a", 4'b0000, 2'b10, 2'd0, 2'd0, 5'd10);
        check();
        expect_out("mc10_busy_b", 4'b0000, 2'b10, 2'd0, 2'd0, 5'd10);
        check();
        expect_out("mc10_done", 4'b0000, 2'b01, 2'd0, 2'd0, 5'd10);
        check();
        expect_out("mc10_idle", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd10);
        check();

        // x0 never hazards or forwards; reset mid-BUSY abandons the op.
        mc_issue(5'd11);
        expect_out("mc11_accept", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd10);
        check();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
        bus.id_wreg = 1'b1; bus.id_rd = 5'd0;
        bus.fwd_wreg = 2'b11; bus.ex_is_load = 1'b1;
        expect_out("x0_no_hazard", 4'b0000, 2'b10, 2'd0, 2'd0, 5'd11);
        check();
        clear_inputs();
        resetn = 1'b0;
        expect_out("mid_busy_reset", 4'b0000, 2'b00, 2'd0, 2'd0, 5'd0);
        check();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("post_reset_%0d", i), 4'b0000, 2'b00, 2'd0, 2'd0, 5'd0);
            check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter NUM_FWD, default 2: number of forwardable downstream stages; stage 0 = EXE, stage 1 = MEM, and so on.
REQ-002 SHALL have parameter MC_LAT, default 4: multicycle-unit latency in cycles; legal values are 2 or more.
REQ-003 SHALL have parameter AW, default 5: register address width.
REQ-004 SHALL derive SELW = clog2(NUM_FWD+2) as the operand select width.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port id_valid, input, 1: ID holds a real instruction.
REQ-008 SHALL have ports id_rs1 and id_rs2, input, AW each: source register addresses.
REQ-009 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: the source is actually read.
REQ-010 SHALL have ports id_rd (input, AW) and id_wreg (input, 1): ID destination register and its write enable.
REQ-011 SHALL have port id_is_mc, input, 1: ID instruction is a multicycle op (mul/div).
REQ-012 SHALL have port fwd_rd, input, NUM_FWD*AW: destination register of stage k in slice k.
REQ-013 SHALL have port fwd_wreg, input, NUM_FWD: write enable of stage k.
REQ-014 SHALL have port ex_is_load, input, 1: stage 0 holds a load.
REQ-015 SHALL have port br_taken, input, 1: EXE redirects the PC.
REQ-016 SHALL have ports qa_sel and qb_sel, output, SELW each: operand source; 0 = regfile, k+1 = stage k, NUM_FWD+1 = multicycle result.
REQ-017 SHALL have outputs pc_stall, ifid_stall, ifid_flush and idex_bubble, 1 each.
REQ-018 SHALL have outputs mc_busy (1), mc_done (1) and mc_rd (AW).

Function
REQ-019 SHALL implement multicycle-unit FSM states IDLE, BUSY and DONE, plus a countdown counter cnt.
REQ-020 SHALL define accept = id_valid & id_is_mc & !stall & !br_taken.
REQ-021 In IDLE or DONE, SHALL on accept capture id_rd into mc_rd, load cnt = MC_LAT-2 and enter BUSY; without accept, DONE SHALL return to IDLE.
REQ-022 In BUSY, SHALL decrement cnt each cycle and enter DONE when cnt == 0; mc_done is therefore high exactly MC_LAT cycles after accept, for one cycle.
REQ-023 SHALL drive mc_busy = (state == BUSY) and mc_done = (state == DONE).
REQ-024 A register match SHALL require the address to be nonzero and the corresponding use or write enable to be set; x0 never causes a hazard or a forward.
REQ-025 SHALL assert load-use stall when ex_is_load & fwd_wreg[0] and fwd_rd[0] matches a used source.
REQ-026 SHALL assert MC RAW stall when BUSY and mc_rd matches a used source.
REQ-027 SHALL assert MC WAW stall when BUSY & id_wreg & id_rd == mc_rd.
REQ-028 SHALL assert MC structural stall when BUSY & id_is_mc.
REQ-029 SHALL define stall = id_valid & (any of the REQ-025 to REQ-028 conditions).
REQ-030 When stall is high, SHALL drive pc_stall = ifid_stall = idex_bubble = 1.
REQ-031 br_taken SHALL override stall, driving ifid_flush = idex_bubble = 1 and pc_stall = ifid_stall = 0 in the same cycle.
REQ-032 An in-flight multicycle op SHALL NOT be cancelled by br_taken.
REQ-033 Forward selection SHALL give the lowest matching stage k priority, then the multicycle result in DONE with matching mc_rd, then the regfile.
REQ-034 All stall, flush and select outputs SHALL be combinational from the current inputs and state, with zero-cycle latency.

Reset
REQ-035 On resetn low, SHALL asynchronously force state = IDLE, cnt = 0 and mc_rd = 0; mc_busy and mc_done SHALL read 0.
REQ-036 A reset asserted mid-BUSY SHALL abandon the op; no mc_done SHALL follow the deassertion of reset.

Structure
REQ-037 SHALL place the FSM state enum, the select encodings (SEL_RF, SEL_MC) and the SELW function in a shared package hazard_pkg.
REQ-038 SHALL implement per-operand priority matching in sub-module fwd_match, instantiated twice (rs1 and rs2).

Verification
REQ-039 Bench SHALL apply: load in EXE with rd = 5, ID rs1 = 5 used -> one cycle of pc_stall, ifid_stall and idex_bubble, then qa_sel = 2 (forward from MEM).
REQ-040 Bench SHALL apply: EXE and MEM both writing x7, ID rs2 = 7 -> qb_sel = 1 (EXE wins).
REQ-041 Bench SHALL apply: mc op rd = 3 accepted, MC_LAT = 4, next instruction reads x3 -> stalled 3 cycles, then qa_sel = NUM_FWD+1 in the DONE cycle.
REQ-042 Bench SHALL apply: second mc op while BUSY -> stalled until DONE, then accepted in DONE, entering BUSY directly.
REQ-043 Bench SHALL apply: br_taken concurrent with a load-use hazard -> ifid_flush = 1, idex_bubble = 1, pc_stall = 0.
REQ-044 Bench SHALL apply: rd = 0 writes and rs = 0 reads, plus resetn pulsed mid-BUSY -> no stall and sel = 0; state returns to IDLE and mc_done is never raised.
